// File: rtl/data_memory_responder.sv
// ============================================================================
// data_memory_responder : data-memory responder with programmable wait states
// Revision 1.0
// ============================================================================
`default_nettype none

module data_memory_responder #(
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output logic        busy
);

    localparam int         c_depth     = 2 ** ADDR_WIDTH;
    localparam logic [3:0] c_wait_init = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_COMMIT = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [3:0]              r_count;
    logic                    r_write;
    logic                    r_error;
    logic [ADDR_WIDTH-1:0]   r_index;
    logic [31:0]             r_wdata;
    logic [31:0]             r_rdata;
    logic                    r_rsp_error;
    logic [31:0]             mem [c_depth];

    logic w_accept;
    logic w_req_error;
    logic w_commit;
    logic w_mem_we;

    assign w_accept    = (r_state == ST_IDLE) && req_valid;
    // Misaligned byte address, or any address bit above the RAM's word range.
    assign w_req_error = (req_addr[1:0] != 2'b00) ||
                         ((req_addr >> (ADDR_WIDTH + 2)) != 32'd0);
    assign w_commit    = (r_state == ST_COMMIT);
    assign w_mem_we    = w_commit && r_write && !r_error;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_state_next = (c_wait_init != 4'd0) ? ST_WAIT : ST_COMMIT;
                end
            end
            ST_WAIT: begin
                if (r_count == 4'd1) begin
                    w_state_next = ST_COMMIT;
                end
            end
            ST_COMMIT: w_state_next = ST_RESP;
            ST_RESP:   w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= 4'd0;
            r_write <= 1'b0;
            r_error <= 1'b0;
            r_index <= '0;
            r_wdata <= 32'd0;
        end else if (w_accept) begin
            r_count <= c_wait_init;
            r_write <= req_write;
            r_error <= w_req_error;
            r_index <= req_addr[ADDR_WIDTH+1:2];
            r_wdata <= req_wdata;
        end else if (r_state == ST_WAIT) begin
            r_count <= r_count - 4'd1;
        end
    end

    // Response data is only non-zero in the cycle right after COMMIT (RESP).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rdata     <= 32'd0;
            r_rsp_error <= 1'b0;
        end else if (w_commit) begin
            r_rdata     <= (!r_write && !r_error) ? mem[r_index] : 32'd0;
            r_rsp_error <= r_error;
        end else begin
            r_rdata     <= 32'd0;
            r_rsp_error <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            mem[r_index] <= r_wdata;
        end
    end

    assign req_ready = (r_state == ST_IDLE) && reset;
    assign rsp_valid = (r_state == ST_RESP);
    assign rsp_rdata = r_rdata;
    assign rsp_error = r_rsp_error;
    assign busy      = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_data_memory_responder.sv
// ============================================================================
// tb_data_memory_responder : randomized self-checking bench, two wait settings
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_data_memory_responder;

    logic        clk = 1'b0;
    logic        reset_a = 1'b1;
    logic        reset_b = 1'b1;
    logic        sel = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;

    logic        valid_a, valid_b;
    logic        ready_a, rsp_valid_a, err_a, busy_a;
    logic        ready_b, rsp_valid_b, err_b, busy_b;
    logic [31:0] rdata_a, rdata_b;
    logic        ready_s, rsp_valid_s, err_s, busy_s;
    logic [31:0] rdata_s;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rsp_cnt_a = 0;
    int rsp_cnt_b = 0;

    // Reference memory per instance: index 0 = WAIT_CYCLES 2, index 1 = WAIT_CYCLES 0.
    logic [31:0] mem_m [2][256];
    bit          known_m [2][256];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge rsp_valid_a) rsp_cnt_a++;
    always @(posedge rsp_valid_b) rsp_cnt_b++;

    assign valid_a     = req_valid & ~sel;
    assign valid_b     = req_valid & sel;
    assign ready_s     = sel ? ready_b : ready_a;
    assign rsp_valid_s = sel ? rsp_valid_b : rsp_valid_a;
    assign rdata_s     = sel ? rdata_b : rdata_a;
    assign err_s       = sel ? err_b : err_a;
    assign busy_s      = sel ? busy_b : busy_a;

    data_memory_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(2)) u_dut_a (
        .clk(clk), .reset(reset_a), .req_valid(valid_a), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(ready_a),
        .rsp_valid(rsp_valid_a), .rsp_rdata(rdata_a), .rsp_error(err_a), .busy(busy_a)
    );

    data_memory_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(0)) u_dut_b (
        .clk(clk), .reset(reset_b), .req_valid(valid_b), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(ready_b),
        .rsp_valid(rsp_valid_b), .rsp_rdata(rdata_b), .rsp_error(err_b), .busy(busy_b)
    );

    // One full transaction with checks of latency, pulse width, error and data.
    task automatic do_req(input bit s, input bit wr, input logic [31:0] addr,
                          input logic [31:0] wd, input string tag);
        int          w;
        bit          e;
        bit          chk;
        logic [31:0] exp_rd;
        logic [7:0]  ix;
        int          lat;
        int          t;
        logic [31:0] got_rd;
        logic        got_err;
        w      = s ? 0 : 2;
        ix     = addr[9:2];
        e      = (addr[1:0] != 2'b00) || (addr >= 32'h400);
        chk    = e || wr || known_m[s][ix];
        exp_rd = (e || wr) ? 32'd0 : mem_m[s][ix];
        got_rd = 32'd0;
        got_err = 1'b0;
        @(negedge clk);
        sel = s; req_write = wr; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
        t = 0;
        while (ready_s !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (ready_s !== 1'b1) begin
            errors++;
            $display("FAIL %s accept: req_ready=%b required 1 within 50 cycles", tag, ready_s);
            req_valid = 1'b0;
            return;
        end
        @(negedge clk);
        req_valid = 1'b0;
        req_write = 1'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
        lat = -1;
        for (int n = 0; n < 20; n++) begin
            if (rsp_valid_s === 1'b1) begin
                lat = n;
                got_rd = rdata_s;
                got_err = err_s;
                break;
            end
            checks++;
            if (rdata_s !== 32'd0 || err_s !== 1'b0 || busy_s !== 1'b1) begin
                errors++;
                $display("FAIL %s in-flight: rdata=%h err=%b busy=%b required 0/0/1",
                         tag, rdata_s, err_s, busy_s);
            end
            @(negedge clk);
        end
        // Accepted at edge E, RESP occupies the cycle after edge E+W+1.
        checks++;
        if (lat != w + 1) begin
            errors++;
            $display("FAIL %s latency: got %0d edges required %0d", tag, lat, w + 1);
        end
        if (lat >= 0) begin
            checks++;
            if (got_err !== e) begin
                errors++;
                $display("FAIL %s rsp_error: got %b required %b", tag, got_err, e);
            end
            if (chk) begin
                checks++;
                if (got_rd !== exp_rd) begin
                    errors++;
                    $display("FAIL %s rsp_rdata: got %h required %h", tag, got_rd, exp_rd);
                end
            end
            @(negedge clk);
            checks++;
            if (rsp_valid_s !== 1'b0 || rdata_s !== 32'd0) begin
                errors++;
                $display("FAIL %s pulse: rsp_valid=%b rdata=%h required 0/0",
                         tag, rsp_valid_s, rdata_s);
            end
        end
        if (!e && wr) begin
            mem_m[s][ix]   = wd;
            known_m[s][ix] = 1'b1;
        end
    endtask

    task automatic test_reset();
        #1;
        reset_a = 1'b0;
        reset_b = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if ({ready_a, rsp_valid_a, err_a, busy_a, rdata_a,
                 ready_b, rsp_valid_b, err_b, busy_b, rdata_b} !== 72'd0) begin
                errors++;
                $display("FAIL reset outputs: a=%b%b%b%b/%h b=%b%b%b%b/%h required all 0",
                         ready_a, rsp_valid_a, err_a, busy_a, rdata_a,
                         ready_b, rsp_valid_b, err_b, busy_b, rdata_b);
            end
        end
        reset_a = 1'b1;
        reset_b = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (ready_a !== 1'b1 || busy_a !== 1'b0 || ready_b !== 1'b1 || busy_b !== 1'b0) begin
            errors++;
            $display("FAIL reset release: ready=%b%b busy=%b%b required 11/00",
                     ready_a, ready_b, busy_a, busy_b);
        end
    endtask

    task automatic test_store_load();
        do_req(0, 1'b1, 32'h10, 32'hDEADBEEF, "store_0x10");
        do_req(0, 1'b0, 32'h10, 32'h0, "load_0x10");
    endtask

    task automatic test_misaligned();
        do_req(0, 1'b1, 32'h12, 32'h12345678, "store_misaligned");
        do_req(0, 1'b0, 32'h10, 32'h0, "load_after_misaligned");
        do_req(0, 1'b0, 32'h13, 32'h0, "load_misaligned");
    endtask

    task automatic test_out_of_range();
        do_req(0, 1'b0, 32'h400, 32'h0, "load_0x400");
        do_req(0, 1'b1, 32'h8000_0010, 32'h55AA55AA, "store_high_bit");
        do_req(0, 1'b0, 32'h10, 32'h0, "load_after_oor");
        do_req(0, 1'b0, 32'h3FC, 32'h0, "load_top_word");
    endtask

    task automatic test_back_to_back();
        int          acc [4];
        logic [31:0] d [4];
        int          c0;
        int          t;
        c0 = rsp_cnt_a;
        @(negedge clk);
        sel = 1'b0;
        req_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            d[k] = $urandom;
            req_write = 1'b1;
            req_addr  = 32'h80 + 32'(k * 4);
            req_wdata = d[k];
            t = 0;
            while (ready_s !== 1'b1 && t < 50) begin
                @(negedge clk);
                t++;
            end
            checks++;
            if (ready_s !== 1'b1) begin
                errors++;
                $display("FAIL b2b accept %0d: req_ready=%b required 1", k, ready_s);
            end
            @(posedge clk);
            #1;
            acc[k] = cyc;
            @(negedge clk);
        end
        req_valid = 1'b0;
        for (int k = 1; k < 4; k++) begin
            checks++;
            if (acc[k] - acc[k-1] != 5) begin
                errors++;
                $display("FAIL b2b spacing %0d: got %0d cycles required 5", k, acc[k] - acc[k-1]);
            end
        end
        repeat (6) @(negedge clk);
        checks++;
        if (rsp_cnt_a - c0 != 4) begin
            errors++;
            $display("FAIL b2b responses: got %0d required 4", rsp_cnt_a - c0);
        end
        for (int k = 0; k < 4; k++) begin
            mem_m[0][8'h20 + 8'(k)]   = d[k];
            known_m[0][8'h20 + 8'(k)] = 1'b1;
        end
        for (int k = 0; k < 4; k++) begin
            do_req(0, 1'b0, 32'h80 + 32'(k * 4), 32'h0, "b2b_readback");
        end
    endtask

    task automatic test_random();
        logic [31:0] addr;
        int          kind;
        for (int i = 0; i < 24; i++) begin
            addr = 32'h100 + 32'($urandom_range(0, 7) * 4);
            kind = $urandom_range(0, 9);
            if (kind == 0) addr = addr + 32'($urandom_range(1, 3));
            if (kind == 1) addr = addr | (32'd1 << $urandom_range(10, 31));
            do_req(0, 1'($urandom), addr, $urandom, "random");
        end
    endtask

    task automatic test_reset_mid(input bit s);
        logic [31:0] prior;
        int          c0;
        int          t;
        prior = $urandom;
        do_req(s, 1'b1, 32'h20, prior, "abort_prior");
        c0 = s ? rsp_cnt_b : rsp_cnt_a;
        @(negedge clk);
        sel = s; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'hCAFEF00D; req_valid = 1'b1;
        t = 0;
        while (ready_s !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        checks++;
        if (busy_s !== 1'b1) begin
            errors++;
            $display("FAIL abort in-flight: busy=%b required 1", busy_s);
        end
        req_valid = 1'b0;
        if (s) reset_b = 1'b0;
        else   reset_a = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (ready_s !== 1'b0 || busy_s !== 1'b0 || rsp_valid_s !== 1'b0) begin
                errors++;
                $display("FAIL abort reset outputs: ready=%b busy=%b rsp_valid=%b required 0/0/0",
                         ready_s, busy_s, rsp_valid_s);
            end
        end
        reset_a = 1'b1;
        reset_b = 1'b1;
        @(negedge clk);
        checks++;
        if (ready_s !== 1'b1) begin
            errors++;
            $display("FAIL abort release: req_ready=%b required 1", ready_s);
        end
        repeat (4) @(negedge clk);
        checks++;
        if ((s ? rsp_cnt_b : rsp_cnt_a) != c0) begin
            errors++;
            $display("FAIL abort rsp_count: got %0d required %0d", s ? rsp_cnt_b : rsp_cnt_a, c0);
        end
        do_req(s, 1'b0, 32'h20, 32'h0, "abort_readback");
    endtask

    task automatic test_wait_zero();
        logic [31:0] d;
        d = $urandom;
        do_req(1, 1'b1, 32'h10, d, "w0_store");
        do_req(1, 1'b0, 32'h10, 32'h0, "w0_load");
        do_req(1, 1'b0, 32'h11, 32'h0, "w0_misaligned");
    endtask

    initial begin
        for (int j = 0; j < 256; j++) begin
            known_m[0][j] = 1'b0;
            known_m[1][j] = 1'b0;
            mem_m[0][j]   = 32'd0;
            mem_m[1][j]   = 32'd0;
        end
        test_reset();
        test_store_load();
        test_misaligned();
        test_out_of_range();
        test_back_to_back();
        test_random();
        test_reset_mid(0);
        test_wait_zero();
        test_reset_mid(1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
